// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and helpers for the 2-write / 2-read
//                register file with pending-write scoreboard.
//                - DATA_W_DEF / ADDR_W_DEF : default word and address widths
//                - BYTE_W / BYTES          : byte lane width and lane count
//                - byte_merge()            : byte-lane write-enable merge
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int BYTE_W     = 8;
    localparam int BYTES      = DATA_W_DEF / BYTE_W;

    // One byte lane of a masked write: take the new byte when enabled.
    function automatic logic [BYTE_W-1:0] byte_merge(
        input logic [BYTE_W-1:0] old_b,
        input logic [BYTE_W-1:0] new_b,
        input logic              be
    );
        byte_merge = be ? new_b : old_b;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Pending-write scoreboard. One bit per register entry; a
//                write clears it, a claim sets it (claim wins on collision).
//                Two registered lookups report the post-update pending state
//                of the read addresses.
//  Ports       : clk, rst (async, active-high), en_i global enable
//                clr0_i/clr0_addr_i, clr1_i/clr1_addr_i : clear ports
//                set_i/set_addr_i                       : set (claim) port
//                lk_en_i, lk_addr_a_i, lk_addr_b_i      : lookup launch
//                busy_a_o, busy_b_o                     : registered lookups
//                pending_o                              : pending vector
//  Revision    : 1.0  initial release
// ============================================================================
module rf_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2**ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              clr0_i,
    input  logic [ADDR_W-1:0] clr0_addr_i,
    input  logic              clr1_i,
    input  logic [ADDR_W-1:0] clr1_addr_i,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              lk_en_i,
    input  logic [ADDR_W-1:0] lk_addr_a_i,
    input  logic [ADDR_W-1:0] lk_addr_b_i,
    output logic              busy_a_o,
    output logic              busy_b_o,
    output logic [DEPTH-1:0]  pending_o
);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic             busy_a_q, busy_b_q;

    // Clears first, then the set, so a same-cycle claim overrides writeback.
    always_comb begin
        pend_d = pend_q;
        if (clr0_i) pend_d[clr0_addr_i] = 1'b0;
        if (clr1_i) pend_d[clr1_addr_i] = 1'b0;
        if (set_i)  pend_d[set_addr_i]  = 1'b1;
        if (ZERO_REG) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
        end else if (en_i) begin
            pend_q <= pend_d;
            if (lk_en_i) begin
                busy_a_q <= pend_d[lk_addr_a_i];
                busy_b_q <= pend_d[lk_addr_b_i];
            end
        end
    end

    assign pending_o = pend_q;
    assign busy_a_o  = busy_a_q;
    assign busy_b_o  = busy_b_q;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2w2r_sb
//  Description : 2-write / 2-read register file with per-byte write enables,
//                registered reads (optional same-cycle write bypass) and a
//                built-in pending-write scoreboard.
//  Ports       : clk, rst (async, active-high), en_i global enable
//                rd_en_i, ra_a_i, ra_b_i      : read launch and addresses
//                rdata_a_o, rdata_b_o         : registered read data
//                rbusy_a_o, rbusy_b_o         : registered pending status
//                rvalid_o                     : read results valid
//                we0_i/wa0_i/wd0_i/wbe0_i     : write port 0 (ALU writeback)
//                we1_i/wa1_i/wd1_i/wbe1_i     : write port 1 (load writeback)
//                claim_i, claim_addr_i        : mark destination pending
//                pending_o                    : scoreboard vector
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_2w2r_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     rd_en_i,
    input  logic [ADDR_W-1:0]        ra_a_i,
    input  logic [ADDR_W-1:0]        ra_b_i,
    output logic [DATA_W-1:0]        rdata_a_o,
    output logic [DATA_W-1:0]        rdata_b_o,
    output logic                     rbusy_a_o,
    output logic                     rbusy_b_o,
    output logic                     rvalid_o,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        wa0_i,
    input  logic [DATA_W-1:0]        wd0_i,
    input  logic [DATA_W/BYTE_W-1:0] wbe0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        wa1_i,
    input  logic [DATA_W-1:0]        wd1_i,
    input  logic [DATA_W/BYTE_W-1:0] wbe1_i,
    input  logic                     claim_i,
    input  logic [ADDR_W-1:0]        claim_addr_i,
    output logic [2**ADDR_W-1:0]     pending_o
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int NBYTES = DATA_W / BYTE_W;

    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        for (int k = 0; k < NBYTES; k++) begin
            res[k*BYTE_W +: BYTE_W] = byte_merge(old_w[k*BYTE_W +: BYTE_W],
                                                 new_w[k*BYTE_W +: BYTE_W], be[k]);
        end
        return res;
    endfunction

    // w_cur: stored value; w_next: value after this cycle's writes
    // (port 0 applied first, port 1 on top so it wins overlapping bytes).
    logic [DATA_W-1:0] w_cur  [DEPTH];
    logic [DATA_W-1:0] w_next [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if (ZERO_REG && gi == 0) begin : g_zero
            assign w_cur[gi]  = '0;
            assign w_next[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] mem_q;
            logic [NBYTES-1:0] be0_w, be1_w;

            assign be0_w = (we0_i && wa0_i == ADDR_W'(gi)) ? wbe0_i : '0;
            assign be1_w = (we1_i && wa1_i == ADDR_W'(gi)) ? wbe1_i : '0;
            assign w_cur[gi]  = mem_q;
            assign w_next[gi] = merge_word(merge_word(mem_q, wd0_i, be0_w), wd1_i, be1_w);

            always_ff @(posedge clk or posedge rst) begin
                if (rst)       mem_q <= '0;
                else if (en_i) mem_q <= w_next[gi];
            end
        end
    end

    logic [DATA_W-1:0] rsel_a_w, rsel_b_w;
    assign rsel_a_w = BYPASS ? w_next[ra_a_i] : w_cur[ra_a_i];
    assign rsel_b_w = BYPASS ? w_next[ra_b_i] : w_cur[ra_b_i];

    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    logic              rvalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            rvalid_q <= en_i & rd_en_i;
            if (en_i && rd_en_i) begin
                rdata_a_q <= rsel_a_w;
                rdata_b_q <= rsel_b_w;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .clr0_i      (we0_i),
        .clr0_addr_i (wa0_i),
        .clr1_i      (we1_i),
        .clr1_addr_i (wa1_i),
        .set_i       (claim_i),
        .set_addr_i  (claim_addr_i),
        .lk_en_i     (rd_en_i),
        .lk_addr_a_i (ra_a_i),
        .lk_addr_b_i (ra_b_i),
        .busy_a_o    (rbusy_a_o),
        .busy_b_o    (rbusy_b_o),
        .pending_o   (pending_o)
    );

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;
    assign rvalid_o  = rvalid_q;

endmodule : regfile_2w2r_sb
`default_nettype wire

// File: tb/tb_regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_2w2r_sb
//  Description : Directed self-checking bench for regfile_2w2r_sb. Two
//                instances share stimulus: u_dut (BYPASS=1) and u_dut_nb
//                (BYPASS=0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_2w2r_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, rd_en, we0, we1, claim;
    logic [AW-1:0] ra_a, ra_b, wa0, wa1, claim_addr;
    logic [DW-1:0] wd0, wd1;
    logic [3:0]    wbe0, wbe1;

    logic [DW-1:0] rdata_a, rdata_b, rdata_a_nb, rdata_b_nb;
    logic          rbusy_a, rbusy_b, rvalid, rbusy_a_nb, rbusy_b_nb, rvalid_nb;
    logic [D-1:0]  pending, pending_nb;

    int cnt_checks = 0;
    int cnt_fail   = 0;

    always #5 clk = ~clk;

    regfile_2w2r_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .en_i(en), .rd_en_i(rd_en), .ra_a_i(ra_a), .ra_b_i(ra_b),
        .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .rbusy_a_o(rbusy_a), .rbusy_b_o(rbusy_b),
        .rvalid_o(rvalid), .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .wbe0_i(wbe0),
        .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1), .wbe1_i(wbe1),
        .claim_i(claim), .claim_addr_i(claim_addr), .pending_o(pending)
    );

    regfile_2w2r_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .en_i(en), .rd_en_i(rd_en), .ra_a_i(ra_a), .ra_b_i(ra_b),
        .rdata_a_o(rdata_a_nb), .rdata_b_o(rdata_b_nb), .rbusy_a_o(rbusy_a_nb),
        .rbusy_b_o(rbusy_b_nb), .rvalid_o(rvalid_nb),
        .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .wbe0_i(wbe0),
        .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1), .wbe1_i(wbe1),
        .claim_i(claim), .claim_addr_i(claim_addr), .pending_o(pending_nb)
    );

    task automatic idle();
        en = 1'b1; rd_en = 1'b0; we0 = 1'b0; we1 = 1'b0; claim = 1'b0;
        ra_a = '0; ra_b = '0; wa0 = '0; wa1 = '0; claim_addr = '0;
        wd0 = '0; wd1 = '0; wbe0 = '0; wbe1 = '0;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        cnt_checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            cnt_fail++; $display("FAIL reset_rdata: got a=%h b=%h want 0", rdata_a, rdata_b);
        end
        cnt_checks++;
        if (rvalid !== 1'b0 || rbusy_a !== 1'b0 || rbusy_b !== 1'b0) begin
            cnt_fail++; $display("FAIL reset_flags: got rvalid=%b busy=%b%b want 000", rvalid, rbusy_a, rbusy_b);
        end
        cnt_checks++;
        if (pending !== 32'h0) begin
            cnt_fail++; $display("FAIL reset_pending: got %h want 0", pending);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_byte_write();
        idle();
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAABBCCDD; wbe0 = 4'b0101;
        tick();
        cnt_checks++;
        if (rvalid !== 1'b0) begin
            cnt_fail++; $display("FAIL bw_novalid: got rvalid=%b want 0", rvalid);
        end
        idle();
        rd_en = 1'b1; ra_a = 5'd3; ra_b = 5'd0;
        tick();
        cnt_checks++;
        if (rvalid !== 1'b1 || rdata_a !== 32'h00BB00DD || rdata_b !== 32'h0) begin
            cnt_fail++;
            $display("FAIL bw_read: got v=%b a=%h b=%h want v=1 a=00bb00dd b=0", rvalid, rdata_a, rdata_b);
        end
        idle();
        tick();
        cnt_checks++;
        if (rvalid !== 1'b0 || rdata_a !== 32'h00BB00DD) begin
            cnt_fail++; $display("FAIL bw_hold: got v=%b a=%h want v=0 a=00bb00dd", rvalid, rdata_a);
        end
    endtask

    task automatic test_same_cycle_merge();
        idle();
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11111111; wbe0 = 4'hF;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h22222222; wbe1 = 4'b0011;
        rd_en = 1'b1; ra_a = 5'd5;
        tick();
        cnt_checks++;
        if (rdata_a !== 32'h11112222) begin
            cnt_fail++; $display("FAIL merge_bypass: got %h want 11112222", rdata_a);
        end
        cnt_checks++;
        if (rdata_a_nb !== 32'h0) begin
            cnt_fail++; $display("FAIL merge_nobypass_old: got %h want 00000000", rdata_a_nb);
        end
        idle();
        rd_en = 1'b1; ra_a = 5'd5;
        tick();
        cnt_checks++;
        if (rdata_a_nb !== 32'h11112222 || rdata_a !== 32'h11112222) begin
            cnt_fail++;
            $display("FAIL merge_reread: got nb=%h byp=%h want 11112222", rdata_a_nb, rdata_a);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        claim = 1'b1; claim_addr = 5'd7;
        tick();
        cnt_checks++;
        if (pending !== 32'h0000_0080) begin
            cnt_fail++; $display("FAIL sb_claim: got pending=%h want 00000080", pending);
        end
        idle();
        rd_en = 1'b1; ra_a = 5'd7; ra_b = 5'd5;
        tick();
        cnt_checks++;
        if (rbusy_a !== 1'b1 || rbusy_b !== 1'b0) begin
            cnt_fail++; $display("FAIL sb_busy: got a=%b b=%b want a=1 b=0", rbusy_a, rbusy_b);
        end
        idle();
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hCAFEF00D; wbe1 = 4'hF;
        rd_en = 1'b1; ra_a = 5'd7;
        tick();
        cnt_checks++;
        if (rbusy_a !== 1'b0 || rdata_a !== 32'hCAFEF00D || pending !== 32'h0) begin
            cnt_fail++;
            $display("FAIL sb_writeback: got busy=%b data=%h pend=%h want 0 cafef00d 0", rbusy_a, rdata_a, pending);
        end
        // zero-byte writeback still completes; re-claim does not count
        idle();
        claim = 1'b1; claim_addr = 5'd8;
        tick();
        idle();
        claim = 1'b1; claim_addr = 5'd10;
        tick(); tick();
        cnt_checks++;
        if (pending !== 32'h0000_0500) begin
            cnt_fail++; $display("FAIL sb_reclaim: got pending=%h want 00000500", pending);
        end
        idle();
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'hFFFFFFFF; wbe0 = 4'h0;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h0; wbe1 = 4'h1;
        tick();
        cnt_checks++;
        if (pending !== 32'h0) begin
            cnt_fail++; $display("FAIL sb_zero_be_clear: got pending=%h want 0", pending);
        end
        idle();
        rd_en = 1'b1; ra_a = 5'd8;
        tick();
        cnt_checks++;
        if (rdata_a !== 32'h0) begin
            cnt_fail++; $display("FAIL sb_zero_be_data: got %h want 0", rdata_a);
        end
    endtask

    task automatic test_claim_wins_and_zero();
        idle();
        claim = 1'b1; claim_addr = 5'd9;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h12345678; wbe0 = 4'hF;
        rd_en = 1'b1; ra_a = 5'd9;
        tick();
        cnt_checks++;
        if (pending !== 32'h0000_0200 || rbusy_a !== 1'b1 || rdata_a !== 32'h12345678) begin
            cnt_fail++;
            $display("FAIL claim_wins: got pend=%h busy=%b data=%h want 00000200 1 12345678", pending, rbusy_a, rdata_a);
        end
        idle();
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; wbe0 = 4'hF;
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF; wbe1 = 4'hF;
        claim = 1'b1; claim_addr = 5'd0;
        rd_en = 1'b1; ra_a = 5'd0; ra_b = 5'd9;
        tick();
        cnt_checks++;
        if (rdata_a !== 32'h0 || rbusy_a !== 1'b0 || pending !== 32'h0000_0200) begin
            cnt_fail++;
            $display("FAIL zero_reg_same: got data=%h busy=%b pend=%h want 0 0 00000200", rdata_a, rbusy_a, pending);
        end
        idle();
        rd_en = 1'b1; ra_a = 5'd0;
        tick();
        cnt_checks++;
        if (rdata_a !== 32'h0 || rbusy_a !== 1'b0) begin
            cnt_fail++; $display("FAIL zero_reg_after: got data=%h busy=%b want 0 0", rdata_a, rbusy_a);
        end
    endtask

    task automatic test_enable();
        idle();
        rd_en = 1'b1; ra_a = 5'd3;
        tick();
        idle();
        en = 1'b0;
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h0; wbe0 = 4'hF;
        claim = 1'b1; claim_addr = 5'd11;
        rd_en = 1'b1; ra_a = 5'd5; ra_b = 5'd9;
        tick();
        cnt_checks++;
        if (rvalid !== 1'b0 || rdata_a !== 32'h00BB00DD || pending !== 32'h0000_0200) begin
            cnt_fail++;
            $display("FAIL en_freeze: got v=%b data=%h pend=%h want 0 00bb00dd 00000200", rvalid, rdata_a, pending);
        end
        idle();
        rd_en = 1'b1; ra_a = 5'd3; ra_b = 5'd11;
        tick();
        cnt_checks++;
        if (rvalid !== 1'b1 || rdata_a !== 32'h00BB00DD || rbusy_b !== 1'b0) begin
            cnt_fail++;
            $display("FAIL en_no_write: got v=%b data=%h busy_b=%b want 1 00bb00dd 0", rvalid, rdata_a, rbusy_b);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        claim = 1'b1; claim_addr = 5'd12;
        tick();
        cnt_checks++;
        if (pending !== 32'h0000_1200) begin
            cnt_fail++; $display("FAIL rstmid_pre: got pend=%h want 00001200", pending);
        end
        idle();
        rd_en = 1'b1; ra_a = 5'd3; ra_b = 5'd5;
        claim = 1'b1; claim_addr = 5'd13;
        #2 rst = 1'b1;
        #1;
        cnt_checks++;
        if (rdata_a !== 32'h0 || rvalid !== 1'b0 || pending !== 32'h0) begin
            cnt_fail++;
            $display("FAIL rstmid_async: got data=%h v=%b pend=%h want 0 0 0", rdata_a, rvalid, pending);
        end
        tick();
        rst = 1'b0;
        idle();
        rd_en = 1'b1; ra_a = 5'd3; ra_b = 5'd5;
        tick();
        cnt_checks++;
        if (rvalid !== 1'b1 || rdata_a !== 32'h0 || rdata_b !== 32'h0 || pending !== 32'h0) begin
            cnt_fail++;
            $display("FAIL rstmid_cleared: got v=%b a=%h b=%h pend=%h want 1 0 0 0", rvalid, rdata_a, rdata_b, pending);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_byte_write();
        test_same_cycle_merge();
        test_scoreboard();
        test_claim_wins_and_zero();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", cnt_checks, cnt_fail);
        $finish;
    end

endmodule : tb_regfile_2w2r_sb
`default_nettype wire
